// File: rtl/pwm_sample_dac.sv
// pwm_sample_dac: turns a valid/ready stream of unsigned DAC codes into a
// registered single-bit PWM waveform; starved sample slots repeat the code.
module pwm_sample_dac #(
  parameter int CODE_WIDTH         = 10,
  parameter int PERIODS_PER_SAMPLE = 1,
  parameter int UNDERRUN_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CODE_WIDTH-1:0]         code_in,
  input  logic                          code_valid,
  output logic                          code_ready,
  output logic                          pwm_out,
  output logic                          period_start,
  output logic                          underrun,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);

  localparam int PW =
    (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIODS_PER_SAMPLE - 1);
  localparam logic [CODE_WIDTH-1:0] MID =
    {1'b1, {(CODE_WIDTH-1){1'b0}}};

  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] active;
  logic [CODE_WIDTH-1:0] buf_q;
  logic [PW-1:0]         per;
  logic                  buf_full;
  logic                  load_pt;
  logic                  boundary;
  logic                  take;

  assign load_pt      = enable && (cnt == '1);
  assign boundary     = load_pt && (per == PER_LAST);
  assign take         = code_valid && !buf_full;
  assign code_ready   = !buf_full;
  assign period_start = enable && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      per <= '0;
    end else if (!enable) begin
      cnt <= '0;
      per <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (load_pt)
        per <= (per == PER_LAST) ? '0 : per + 1'b1;
    end
  end

  // take requires an empty buffer and a load requires a full one,
  // so the two branches below never compete for buf_q/buf_full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      active   <= MID;
    end else if (take) begin
      buf_q    <= code_in;
      buf_full <= 1'b1;
    end else if (boundary && buf_full) begin
      active   <= buf_q;
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun       <= 1'b0;
      underrun_count <= '0;
      pwm_out        <= 1'b0;
    end else begin
      underrun <= boundary && !buf_full;
      if (boundary && !buf_full && (underrun_count != '1))
        underrun_count <= underrun_count + 1'b1;
      pwm_out <= enable && (cnt < active);
    end
  end

endmodule
